// File: rtl/display_source_arbiter.sv
// Arbitrates the 4-digit display between keypad entry, ALU result and error requesters.
// Optional macro RESULT_TIMEOUT_EN: a shown result times out back to the last accepted entry.
module display_source_arbiter #(
    parameter int          HOLD_CYCLES  = 5000000,
    parameter int          BLINK_CYCLES = 1250000,
    parameter logic [15:0] ERR_PATTERN  = 16'hEEEE
) (
    input  logic        clk5,
    input  logic        reset,
    input  logic        entry_valid,
    input  logic [16:0] entry_val,
    input  logic [3:0]  entry_point,
    output logic        entry_ack,
    input  logic        result_valid,
    input  logic [16:0] result_val,
    output logic        result_ack,
    input  logic        error_valid,
    output logic        error_ack,
    input  logic        error_clear,
    output logic [16:0] dispVal,
    output logic [3:0]  point,
    output logic        blank,
    output logic [1:0]  state_out
);

    localparam int HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ENTRY  = 2'b01,
        RESULT = 2'b10,
        ERROR  = 2'b11
    } state_t;

    state_t        state_q;
    logic [16:0]   disp_q;
    logic [3:0]    point_q;
    logic          blank_q;
    logic          entry_ack_q;
    logic          result_ack_q;
    logic          error_ack_q;
    logic [HW-1:0] hold_cnt_q;
    logic [BW-1:0] blink_cnt_q;
`ifdef RESULT_TIMEOUT_EN
    logic [16:0]   shadow_val_q;
    logic [3:0]    shadow_point_q;
`endif

    // The registered ack masks a valid that is still held during its own ack cycle.
    logic err_acc_d, res_acc_d, ent_acc_d;
    assign err_acc_d = error_valid && !error_ack_q;
    assign res_acc_d = result_valid && !result_ack_q && !err_acc_d && (state_q != ERROR);
    assign ent_acc_d = entry_valid && !entry_ack_q && !err_acc_d && !res_acc_d
                       && (state_q != ERROR);

    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            disp_q         <= '0;
            point_q        <= '0;
            blank_q        <= 1'b0;
            entry_ack_q    <= 1'b0;
            result_ack_q   <= 1'b0;
            error_ack_q    <= 1'b0;
            hold_cnt_q     <= '0;
            blink_cnt_q    <= '0;
`ifdef RESULT_TIMEOUT_EN
            shadow_val_q   <= '0;
            shadow_point_q <= '0;
`endif
        end else begin
            entry_ack_q  <= ent_acc_d;
            result_ack_q <= res_acc_d;
            error_ack_q  <= err_acc_d;
            if (err_acc_d) begin
                state_q     <= ERROR;
                disp_q      <= {1'b0, ERR_PATTERN};
                point_q     <= '0;
                blank_q     <= 1'b0;
                hold_cnt_q  <= HOLD_LOAD;
                blink_cnt_q <= '0;
            end else if (res_acc_d) begin
                state_q     <= RESULT;
                disp_q      <= result_val;
                point_q     <= '0;
                blank_q     <= 1'b0;
                blink_cnt_q <= '0;
`ifdef RESULT_TIMEOUT_EN
                hold_cnt_q  <= HOLD_LOAD;
`else
                hold_cnt_q  <= '0;
`endif
            end else if (ent_acc_d) begin
                state_q     <= ENTRY;
                disp_q      <= entry_val;
                point_q     <= entry_point;
                blank_q     <= 1'b0;
                hold_cnt_q  <= '0;
                blink_cnt_q <= '0;
`ifdef RESULT_TIMEOUT_EN
                shadow_val_q   <= entry_val;
                shadow_point_q <= entry_point;
`endif
            end else begin
                case (state_q)
                    ERROR: begin
                        if (hold_cnt_q == '0 || error_clear) begin
                            state_q     <= IDLE;
                            disp_q      <= '0;
                            point_q     <= '0;
                            blank_q     <= 1'b0;
                            hold_cnt_q  <= '0;
                            blink_cnt_q <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - 1'b1;
                            if (blink_cnt_q == BLINK_TOP) begin
                                blink_cnt_q <= '0;
                                blank_q     <= ~blank_q;
                            end else begin
                                blink_cnt_q <= blink_cnt_q + 1'b1;
                            end
                        end
                    end
`ifdef RESULT_TIMEOUT_EN
                    RESULT: begin
                        if (hold_cnt_q == '0) begin
                            state_q <= ENTRY;
                            disp_q  <= shadow_val_q;
                            point_q <= shadow_point_q;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign entry_ack  = entry_ack_q;
    assign result_ack = result_ack_q;
    assign error_ack  = error_ack_q;
    assign dispVal    = disp_q;
    assign point      = point_q;
    assign blank      = blank_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench for display_source_arbiter (HOLD_CYCLES=20, BLINK_CYCLES=4).
module tb_display_source_arbiter;

    logic        clk5;
    logic        reset;
    logic        entry_valid;
    logic [16:0] entry_val;
    logic [3:0]  entry_point;
    logic        entry_ack;
    logic        result_valid;
    logic [16:0] result_val;
    logic        result_ack;
    logic        error_valid;
    logic        error_ack;
    logic        error_clear;
    logic [16:0] dispVal;
    logic [3:0]  point;
    logic        blank;
    logic [1:0]  state_out;

    int checks = 0;
    int errors = 0;

    display_source_arbiter #(
        .HOLD_CYCLES (20),
        .BLINK_CYCLES(4),
        .ERR_PATTERN (16'hEEEE)
    ) dut (
        .clk5        (clk5),
        .reset       (reset),
        .entry_valid (entry_valid),
        .entry_val   (entry_val),
        .entry_point (entry_point),
        .entry_ack   (entry_ack),
        .result_valid(result_valid),
        .result_val  (result_val),
        .result_ack  (result_ack),
        .error_valid (error_valid),
        .error_ack   (error_ack),
        .error_clear (error_clear),
        .dispVal     (dispVal),
        .point       (point),
        .blank       (blank),
        .state_out   (state_out)
    );

    initial clk5 = 1'b0;
    always #5 clk5 = ~clk5;

    task automatic tick();
        @(posedge clk5);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; entry_valid = 0; entry_val = '0; entry_point = '0;
        result_valid = 0; result_val = '0; error_valid = 0; error_clear = 0;
        tick(); tick();
        chk("rst_state", 32'(state_out), 0);
        chk("rst_disp", 32'(dispVal), 0);
        chk("rst_point", 32'(point), 0);
        chk("rst_blank", 32'(blank), 0);
        chk("rst_acks", {29'd0, entry_ack, result_ack, error_ack}, 0);
        reset = 1'b1;
        tick();

        // entry accept
        entry_val = 17'h01234; entry_point = 4'b0010; entry_valid = 1;
        tick();
        chk("s1_ack", 32'(entry_ack), 1);
        chk("s1_disp", 32'(dispVal), 32'h01234);
        chk("s1_point", 32'(point), 32'b0010);
        chk("s1_state", 32'(state_out), 1);
        entry_valid = 0;
        tick();
        chk("s1_ack_pulse", 32'(entry_ack), 0);

        // result beats entry, entry follows
        result_val = 17'h10042; result_valid = 1; entry_valid = 1;
        tick();
        chk("s2_rack", 32'(result_ack), 1);
        chk("s2_eack0", 32'(entry_ack), 0);
        chk("s2_disp", 32'(dispVal), 32'h10042);
        chk("s2_point", 32'(point), 0);
        chk("s2_state", 32'(state_out), 2);
        result_valid = 0;
        tick();
        chk("s2_eack", 32'(entry_ack), 1);
        chk("s2_rack0", 32'(result_ack), 0);
        chk("s2_disp2", 32'(dispVal), 32'h01234);
        chk("s2_state2", 32'(state_out), 1);
        entry_valid = 0;
        tick();

        // error with blink and timeout, entry blocked meanwhile
        error_valid = 1;
        tick();
        chk("s3_ack", 32'(error_ack), 1);
        chk("s3_state", 32'(state_out), 3);
        chk("s3_disp", 32'(dispVal), 32'h0EEEE);
        chk("s3_blank0", 32'(blank), 0);
        error_valid = 0;
        entry_val = 17'h00777; entry_point = 4'b0100; entry_valid = 1;
        for (int i = 1; i < 20; i++) begin
            tick();
            chk($sformatf("s3_blank_c%0d", i), 32'(blank),
                ((i >= 4 && i < 8) || (i >= 12 && i < 16)) ? 1 : 0);
            chk($sformatf("s3_state_c%0d", i), 32'(state_out), 3);
            chk($sformatf("s3_eblk_c%0d", i), 32'(entry_ack), 0);
        end
        tick();
        chk("s3_exit_state", 32'(state_out), 0);
        chk("s3_exit_disp", 32'(dispVal), 0);
        chk("s3_exit_blank", 32'(blank), 0);
        chk("s3_exit_eack", 32'(entry_ack), 0);
        tick();
        chk("s3_late_eack", 32'(entry_ack), 1);
        chk("s3_late_disp", 32'(dispVal), 32'h00777);
        chk("s3_late_state", 32'(state_out), 1);
        entry_valid = 0;
        tick();

        // error + clear together: error wins and reloads
        error_valid = 1;
        tick();
        chk("s4_ack", 32'(error_ack), 1);
        error_valid = 0;
        repeat (5) tick();
        error_valid = 1; error_clear = 1;
        tick();
        chk("s4_reack", 32'(error_ack), 1);
        chk("s4_stay", 32'(state_out), 3);
        error_valid = 0; error_clear = 0;
        repeat (19) tick();
        chk("s4_hold19", 32'(state_out), 3);
        tick();
        chk("s4_exit20", 32'(state_out), 0);
        error_valid = 1;
        tick();
        error_valid = 0;
        tick();
        chk("s4_in_err", 32'(state_out), 3);
        error_clear = 1;
        tick();
        chk("s4_clear_state", 32'(state_out), 0);
        chk("s4_clear_disp", 32'(dispVal), 0);
        error_clear = 0;
        tick();

        // asynchronous reset mid-error
        error_valid = 1;
        tick();
        error_valid = 0;
        repeat (4) tick();
        chk("s5_pre_blank", 32'(blank), 1);
        #2 reset = 1'b0;
        #1;
        chk("s5_state", 32'(state_out), 0);
        chk("s5_disp", 32'(dispVal), 0);
        chk("s5_point", 32'(point), 0);
        chk("s5_blank", 32'(blank), 0);
        chk("s5_acks", {29'd0, entry_ack, result_ack, error_ack}, 0);
        tick();
        reset = 1'b1;
        tick();

        // result hold / optional timeout
        entry_val = 17'h00009; entry_point = 4'b0000; entry_valid = 1;
        tick();
        entry_valid = 0;
        tick();
        result_val = 17'h00042; result_valid = 1;
        tick();
        chk("s6_rack", 32'(result_ack), 1);
        chk("s6_state", 32'(state_out), 2);
        result_valid = 0;
`ifdef RESULT_TIMEOUT_EN
        repeat (19) tick();
        chk("s6_hold19", 32'(state_out), 2);
        tick();
        chk("s6_to_state", 32'(state_out), 1);
        chk("s6_to_disp", 32'(dispVal), 32'h00009);
`else
        repeat (100) tick();
        chk("s6_keep_disp", 32'(dispVal), 32'h00042);
        chk("s6_keep_state", 32'(state_out), 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
